// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types, sizing constants and helpers for the two-port memory arbiter
//   MEM_SIZE_DEFAULT : default data-memory size in bytes
//   NUM_PORTS        : number of requester ports
//   state_t          : arbiter FSM states
//   req_t            : latched request (addr, we, wdata, size, originating port)
//   byte_mask()      : 64-bit mask keeping the low <size> bytes
package mem_arb_pkg;
  localparam int MEM_SIZE_DEFAULT = 1024;
  localparam int NUM_PORTS = 2;
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;
  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [3:0]  size;
    logic        port;
  } req_t;
  function automatic logic [63:0] byte_mask(input logic [3:0] size);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (i < int'(size)) m[i*8+:8] = 8'hFF;
    return m;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response channels and data-memory signals of the memory arbiter
//   p0_req_* / p1_req_*   : per-port request handshake (valid/ready) with addr, we, wdata, size
//   p0_resp_* / p1_resp_* : per-port one-cycle completion with read data and error flag
//   mem_*                 : single-cycle data-memory drive and its combinational read data
//   modport slave         : arbiter side
//   modport master        : requesters plus memory side
interface mem_arbiter_if;
  logic        p0_req_valid, p1_req_valid;
  logic        p0_req_ready, p1_req_ready;
  logic [63:0] p0_req_addr, p1_req_addr;
  logic        p0_req_we, p1_req_we;
  logic [63:0] p0_req_wdata, p1_req_wdata;
  logic [3:0]  p0_req_size, p1_req_size;
  logic        p0_resp_valid, p1_resp_valid;
  logic [63:0] p0_resp_rdata, p1_resp_rdata;
  logic        p0_resp_err, p1_resp_err;
  logic [63:0] mem_address;
  logic        mem_write_enable, mem_read_enable;
  logic [63:0] mem_write_data;
  logic [3:0]  mem_xfer_size;
  logic [63:0] mem_read_data;
  modport slave (
    input  p0_req_valid, p1_req_valid, p0_req_addr, p1_req_addr, p0_req_we, p1_req_we,
    input  p0_req_wdata, p1_req_wdata, p0_req_size, p1_req_size, mem_read_data,
    output p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid,
    output p0_resp_rdata, p1_resp_rdata, p0_resp_err, p1_resp_err,
    output mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size
  );
  modport master (
    output p0_req_valid, p1_req_valid, p0_req_addr, p1_req_addr, p0_req_we, p1_req_we,
    output p0_req_wdata, p1_req_wdata, p0_req_size, p1_req_size, mem_read_data,
    input  p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid,
    input  p0_resp_rdata, p1_resp_rdata, p0_resp_err, p1_resp_err,
    input  mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin grant
//   valid      : request present per port
//   last_grant : index of the port granted most recently
//   grant      : one-hot grant (all zero when nothing is valid)
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  // On a tie the port that was not served last wins.
  always_comb begin
    grant[0] = valid[0] & (~valid[1] | last_grant);
    grant[1] = valid[1] & (~valid[0] | ~last_grant);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-cycle data memory
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mem_arbiter_if.slave -- p0/p1 request and response channels, mem_* memory drive
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEFAULT
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);
  state_t               state_q, state_d;
  req_t                 req_q, req_d, req_in;
  logic                 last_grant_q, last_grant_d;
  logic                 illegal_q, illegal_d;
  logic [63:0]          rdata_q, rdata_d;
  logic [NUM_PORTS-1:0] grant;
  logic [64:0]          req_end;
  logic                 legal, accept, in_access, in_resp;

  rr_arbiter2 u_rr (
    .valid     ({bus.p1_req_valid, bus.p0_req_valid}),
    .last_grant(last_grant_q),
    .grant     (grant)
  );

  // Candidate request from the granted port and its legality; the end
  // address is computed one bit wider so a huge address cannot wrap into range.
  always_comb begin
    req_in.port  = grant[1];
    req_in.addr  = grant[1] ? bus.p1_req_addr : bus.p0_req_addr;
    req_in.we    = grant[1] ? bus.p1_req_we : bus.p0_req_we;
    req_in.wdata = grant[1] ? bus.p1_req_wdata : bus.p0_req_wdata;
    req_in.size  = grant[1] ? bus.p1_req_size : bus.p0_req_size;
    req_end      = {1'b0, req_in.addr} + 65'(req_in.size);
    legal        = (req_in.size inside {4'd1, 4'd2, 4'd4, 4'd8})
                && ((req_in.addr & 64'(req_in.size - 4'd1)) == 64'd0)
                && (req_end <= 65'(MEM_SIZE));
    accept       = (state_q == IDLE) && (grant != '0);
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    last_grant_d = last_grant_q;
    illegal_d    = illegal_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = legal ? ACCESS : RESP;
          req_d        = req_in;
          last_grant_d = req_in.port;
          illegal_d    = ~legal;
          rdata_d      = '0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = req_q.we ? 64'd0 : bus.mem_read_data & byte_mask(req_q.size);
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is masked by reset_n so it drops the instant reset asserts.
  always_comb begin
    in_access            = (state_q == ACCESS);
    in_resp              = (state_q == RESP);
    bus.p0_req_ready     = reset_n && (state_q == IDLE) && grant[0];
    bus.p1_req_ready     = reset_n && (state_q == IDLE) && grant[1];
    bus.mem_write_enable = in_access & req_q.we;
    bus.mem_read_enable  = in_access & ~req_q.we;
    bus.mem_address      = in_access ? req_q.addr : 64'd0;
    bus.mem_write_data   = in_access ? req_q.wdata : 64'd0;
    bus.mem_xfer_size    = in_access ? req_q.size : 4'd0;
    bus.p0_resp_valid    = in_resp & ~req_q.port;
    bus.p1_resp_valid    = in_resp & req_q.port;
    bus.p0_resp_err      = in_resp & ~req_q.port & illegal_q;
    bus.p1_resp_err      = in_resp & req_q.port & illegal_q;
    bus.p0_resp_rdata    = (in_resp & ~req_q.port) ? rdata_q : 64'd0;
    bus.p1_resp_rdata    = (in_resp & req_q.port) ? rdata_q : 64'd0;
  end

  // Port 1 counts as last served after reset so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      last_grant_q <= 1'b1;
      illegal_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      last_grant_q <= last_grant_d;
      illegal_q    <= illegal_d;
      rdata_q      <= rdata_d;
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default 1024, data memory size in bytes; power of two, >8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 p0_req_valid/p1_req_valid  input  1 each  port request present.
REQ-005 p0_req_ready/p1_req_ready  output  1 each  request accepted this cycle.
REQ-006 pN_req_addr  input  64, pN_req_we  input  1, pN_req_wdata  input  64, pN_req_size  input  4  per-port address, write flag, write data, byte count.
REQ-007 pN_resp_valid  output  1, pN_resp_rdata  output  64, pN_resp_err  output  1  per-port completion, read data, error flag.
REQ-008 mem_address  output  64, mem_write_enable  output  1, mem_read_enable  output  1, mem_write_data  output  64, mem_xfer_size  output  4  data-memory drive.
REQ-009 mem_read_data  input  64  combinational read data from memory.

Function
REQ-010 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accepted legal request; IDLE->RESP on accepted illegal request; ACCESS->RESP always; RESP->IDLE always.
REQ-011 Ready asserted only in IDLE, only to the granted port, only when that port's valid is high; at most one ready per cycle.
REQ-012 Accept = valid & ready at rising edge; request fields latched into internal registers on accept.
REQ-013 Arbitration round-robin: one port valid -> grant it; both valid -> grant port other than last_grant; last_grant updates on accept only.
REQ-014 Requester holds valid and fields stable until accepted; arbiter need not tolerate withdrawal.
REQ-015 Legal request: size in {1,2,4,8}, addr & (size-1) == 0, addr + size <= MEM_SIZE (computed without 64-bit wrap).
REQ-016 ACCESS: mem_address/xfer_size/write_data driven from latched registers; mem_write_enable = latched we; mem_read_enable = ~latched we; exactly one cycle.
REQ-017 Outside ACCESS: both memory enables 0, mem_address/mem_write_data/mem_xfer_size 0.
REQ-018 Read data: mem_read_data captured at end of ACCESS; bytes above size zeroed in resp_rdata.
REQ-019 RESP: resp_valid high exactly one cycle to the originating port only; resp_err = illegal flag; resp_rdata = 0 for writes and errors.
REQ-020 Illegal request never asserts either memory enable.
REQ-021 Latency: accept at edge N -> resp_valid high during cycle N+2 (N+1 for illegal); next accept no earlier than edge N+3 (N+2 for illegal).
REQ-022 Write commits at edge ending ACCESS; read in RESP after a write reflects it.
REQ-023 Responses carry no backpressure; requester must sample in RESP cycle.

Reset
REQ-024 reset_n low forces IDLE, last_grant = port 1 (port 0 wins first tie), all ready/resp_valid/resp_err/enables 0, rdata 0, immediately without clock.
REQ-025 Reset during ACCESS drops write enable before next edge; in-flight request discarded, no response issued.
REQ-026 First accept possible at first rising edge after reset_n deasserts.

Structure
REQ-027 Package mem_arb_pkg holds state enum, MEM_SIZE default, port count 2, request struct (addr, we, wdata, size, port).
REQ-028 Sub-module rr_arbiter2: two valids + last_grant in, one-hot grant out, purely combinational.
REQ-029 Legality check, FSM, response registers live in mem_arbiter; no memory instantiated inside.

Verification
REQ-030 Bench pairs mem_arbiter with the 1024-byte data memory; scoreboard byte-array model.
REQ-031 Port0 write addr 0x10 size 8 data 0x0123456789ABCDEF, then port0 read 0x10 size 8 -> rdata 0x0123456789ABCDEF, err 0, resp at accept+2.
REQ-032 Both valid from reset, writes to 0x20/0x28 -> port0 served first, port1 next; both sustained -> alternating grants 0,1,0,1.
REQ-033 Port1 read addr 0x3 size 4 -> resp_err 1, rdata 0, enables never high, resp at accept+1.
REQ-034 Read addr 0x3F8 size 8 legal; addr 0x400 size 1 and size 3 illegal -> err 1.
REQ-035 reset_n low mid-ACCESS of write 0xFF to 0x40 size 1 -> no resp; subsequent read of 0x40 returns prior contents.
